pio_responder: RTL and testbench

//  Target end of the PIO bus: decodes cmd_vld/addr/rw/data_w from an initiator.

---
 rtl/pio_responder.sv | 105 ++++++++++
 tb/tb_pio_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_responder.sv
// PIO bus target: small register bank (ID, command counter, scratch) with a fixed-latency read pipe.
// Optional PIO_RESP_ERR_EN adds an err output flagging decode-miss reads alongside rd_vld.
module pio_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          NUM_REGS  = 8,
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] ID_VALUE  = 32'hA5A5_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [31:0] data_w,
  output logic [31:0] data_r,
  output logic        rd_vld
`ifdef PIO_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] MISS_DATA = 32'hDEAD_BEEF;
  localparam logic [16:0] END_ADDR  = 17'(BASE_ADDR) + 17'(NUM_REGS);

  logic             cmd;
  logic             hit;
  logic             rd_cmd;
  logic             wr_hit;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cmd_count;
  logic [31:0]      scratch [NUM_REGS];
  logic [31:0]      rd_data_p0;

  logic             vld_p  [RD_LAT];
  logic [31:0]      data_p [RD_LAT];

  // A floating (X/Z) cmd_vld from an idle, tri-stated initiator is not a command.
  assign cmd    = (cmd_vld === 1'b1);
  assign idx    = IDX_W'(addr - BASE_ADDR);
  assign hit    = cmd && ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
  assign rd_cmd = cmd && !rw;
  assign wr_hit = hit && rw && (idx >= IDX_W'(2));

  always_comb begin
    rd_data_p0 = MISS_DATA;
    if (hit) begin
      if (idx == '0)
        rd_data_p0 = ID_VALUE;
      else if (idx == IDX_W'(1))
        rd_data_p0 = cmd_count;
      else
        rd_data_p0 = scratch[idx];
    end
  end

  // Stage p0: command edge. Read data above reflects state before this edge's write/count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_count <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        scratch[i] <= '0;
    end else begin
      if (cmd)
        cmd_count <= cmd_count + 32'd1;
      if (wr_hit)
        scratch[idx] <= data_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++)
        vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_cmd;
      for (int i = 1; i < RD_LAT; i++)
        vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= rd_data_p0;
    for (int i = 1; i < RD_LAT; i++)
      data_p[i] <= data_p[i-1];
  end

  // Output stage: data is forced to zero whenever no response is presented.
  assign rd_vld = vld_p[RD_LAT-1];
  assign data_r = rd_vld ? data_p[RD_LAT-1] : '0;

`ifdef PIO_RESP_ERR_EN
  logic err_p [RD_LAT];

  always_ff @(posedge clk) begin
    err_p[0] <= !hit;
    for (int i = 1; i < RD_LAT; i++)
      err_p[i] <= err_p[i-1];
  end

  assign err = rd_vld && err_p[RD_LAT-1];
`endif

endmodule

// File: tb/tb_pio_responder.sv
// Directed bench for pio_responder (default parameters, RD_LAT=2); err checks compile in with PIO_RESP_ERR_EN.
module tb_pio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic [15:0] addr;
  logic        rw;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        rd_vld;
`ifdef PIO_RESP_ERR_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] rq_data [$];
  int          rq_cyc  [$];
  logic        rq_err  [$];

  pio_responder dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_vld (cmd_vld),
    .addr    (addr),
    .rw      (rw),
    .data_w  (data_w),
    .data_r  (data_r),
    .rd_vld  (rd_vld)
`ifdef PIO_RESP_ERR_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response collector, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_vld === 1'b1) begin
      rq_data.push_back(data_r);
      rq_cyc.push_back(cyc);
`ifdef PIO_RESP_ERR_EN
      rq_err.push_back(err);
`else
      rq_err.push_back(1'b0);
`endif
    end
  end

  task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [31:0] d);
    cmd_vld = v;
    rw      = w;
    addr    = a;
    data_w  = d;
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a);
    drive(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    cmd_vld = 1'b0;
    rw      = 1'b0;
    addr    = 16'h0;
    data_w  = 32'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    rq_data.delete();
    rq_cyc.delete();
    rq_err.delete();
  endtask

  task automatic apply_reset();
    cmd_vld = 1'b0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cmd_vld = 1'b0; rw = 1'b0; addr = 16'h0; data_w = 32'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (rd_vld !== 1'b0) begin fails++; $display("FAIL reset_rd_vld got %b exp 0", rd_vld); end
    tests++;
    if (data_r !== 32'h0) begin fails++; $display("FAIL reset_data_r got %h exp 00000000", data_r); end
`ifdef PIO_RESP_ERR_EN
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_id_read();
    int c;
    clear_q();
    c = cyc;
    rd(16'h0100);
    tests++;
    if (rd_vld !== 1'b0 || data_r !== 32'h0) begin
      fails++; $display("FAIL id_early rd_vld=%b data_r=%h exp 0/00000000", rd_vld, data_r);
    end
    idle(4);
    tests++;
    if (rq_data.size() !== 1) begin
      fails++; $display("FAIL id_count got %0d responses exp 1", rq_data.size());
    end else begin
      tests++;
      if (rq_data[0] !== 32'hA5A5_0001) begin
        fails++; $display("FAIL id_data got %h exp a5a50001", rq_data[0]);
      end
      tests++;
      if (rq_cyc[0] - c !== 2) begin
        fails++; $display("FAIL id_latency got %0d exp 2", rq_cyc[0] - c);
      end
`ifdef PIO_RESP_ERR_EN
      tests++;
      if (rq_err[0] !== 1'b0) begin fails++; $display("FAIL id_err got %b exp 0", rq_err[0]); end
`endif
    end
  endtask

  task automatic test_write_read();
    clear_q();
    wr(16'h0103, 32'h1234_5678);
    rd(16'h0103);
    wr(16'h0100, 32'h0000_0000);
    rd(16'h0100);
    idle(4);
    tests++;
    if (rq_data.size() !== 2) begin
      fails++; $display("FAIL wr_rd_count got %0d exp 2", rq_data.size());
    end else begin
      tests++;
      if (rq_data[0] !== 32'h1234_5678) begin
        fails++; $display("FAIL wr_rd_data got %h exp 12345678", rq_data[0]);
      end
      tests++;
      if (rq_data[1] !== 32'hA5A5_0001) begin
        fails++; $display("FAIL id_readonly got %h exp a5a50001", rq_data[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    logic [31:0] exp_d [3];
    exp_d = '{32'hAAAA_0002, 32'h1234_5678, 32'hCCCC_0004};
    wr(16'h0102, 32'hAAAA_0002);
    wr(16'h0104, 32'hCCCC_0004);
    clear_q();
    c = cyc;
    rd(16'h0102);
    rd(16'h0103);
    rd(16'h0104);
    idle(4);
    tests++;
    if (rq_data.size() !== 3) begin
      fails++; $display("FAIL b2b_count got %0d exp 3", rq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rq_data[i] !== exp_d[i]) begin
          fails++; $display("FAIL b2b_data[%0d] got %h exp %h", i, rq_data[i], exp_d[i]);
        end
        tests++;
        if (rq_cyc[i] !== c + 2 + i) begin
          fails++; $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, rq_cyc[i], c + 2 + i);
        end
      end
    end
  endtask

  task automatic test_miss();
    logic [31:0] exp_d [6];
    logic        exp_e [6];
    exp_d = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hAAAA_0002, 32'h1234_5678, 32'hCCCC_0004, 32'h0000_0077};
    exp_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    clear_q();
    rd(16'h00FF);
    rd(16'h0108);
    wr(16'h0108, 32'hFFFF_FFFF);
    wr(16'h00FF, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 16'h0102, 32'hFFFF_FFFF);
    wr(16'h0107, 32'h0000_0077);
    rd(16'h0102);
    rd(16'h0103);
    rd(16'h0104);
    rd(16'h0107);
    idle(4);
    tests++;
    if (rq_data.size() !== 6) begin
      fails++; $display("FAIL miss_count got %0d exp 6", rq_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (rq_data[i] !== exp_d[i]) begin
          fails++; $display("FAIL miss_data[%0d] got %h exp %h", i, rq_data[i], exp_d[i]);
        end
`ifdef PIO_RESP_ERR_EN
        tests++;
        if (rq_err[i] !== exp_e[i]) begin
          fails++; $display("FAIL miss_err[%0d] got %b exp %b", i, rq_err[i], exp_e[i]);
        end
`endif
      end
    end
  endtask

  task automatic test_cmd_count();
    apply_reset();
    clear_q();
    wr(16'h0102, 32'h0000_0001);
    rd(16'h0100);
    wr(16'h0200, 32'h0000_0009);
    rd(16'h00FF);
    wr(16'h0105, 32'h0000_0005);
    rd(16'h0101);
    drive(1'bz, 1'b0, 16'h0101, 32'h0);
    drive(1'bz, 1'b1, 16'h0102, 32'hFFFF_FFFF);
    drive(1'bz, 1'b0, 16'h0101, 32'h0);
    rd(16'h0101);
    rd(16'h0102);
    idle(4);
    tests++;
    if (rq_data.size() !== 5) begin
      fails++; $display("FAIL count_resps got %0d exp 5", rq_data.size());
    end else begin
      tests++;
      if (rq_data[2] !== 32'd5) begin
        fails++; $display("FAIL count_after5 got %h exp 00000005", rq_data[2]);
      end
      tests++;
      if (rq_data[3] !== 32'd6) begin
        fails++; $display("FAIL count_after_z got %h exp 00000006", rq_data[3]);
      end
      tests++;
      if (rq_data[4] !== 32'd1) begin
        fails++; $display("FAIL z_write_dropped got %h exp 00000001", rq_data[4]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_q();
    wr(16'h0103, 32'h0000_0099);
    rd(16'h0102);
    rst     = 1'b0;
    cmd_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(5);
    tests++;
    if (rq_data.size() !== 0) begin
      fails++; $display("FAIL midflight_discard got %0d responses exp 0", rq_data.size());
    end
    clear_q();
    rd(16'h0101);
    rd(16'h0103);
    idle(4);
    tests++;
    if (rq_data.size() !== 2) begin
      fails++; $display("FAIL post_reset_count got %0d exp 2", rq_data.size());
    end else begin
      tests++;
      if (rq_data[0] !== 32'h0) begin
        fails++; $display("FAIL post_reset_cmdcount got %h exp 00000000", rq_data[0]);
      end
      tests++;
      if (rq_data[1] !== 32'h0) begin
        fails++; $display("FAIL post_reset_scratch got %h exp 00000000", rq_data[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_read();
    test_back_to_back();
    test_miss();
    test_cmd_count();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
